// File: rtl/spram_pkg.sv
// Shared sizing constants and access-mode encoding for the SPRAM model.
package spram_pkg;

  localparam int SPRAM_AW      = 14;
  localparam int SPRAM_DW      = 16;
  localparam int SPRAM_NIBBLES = SPRAM_DW / 4;
  localparam int SPRAM_DEPTH   = 1 << SPRAM_AW;

  // Resolved per-edge mode, highest priority first.
  typedef enum logic [2:0] {
    MODE_OFF,
    MODE_SLEEP,
    MODE_STANDBY,
    MODE_IDLE,
    MODE_ACCESS
  } spram_mode_e;

endpackage

// File: rtl/spram_nibble_lane.sv
// One 4-bit-wide slice of the SPRAM array with its own write enable and bulk clear.
module spram_nibble_lane
  import spram_pkg::*;
(
  input  logic                clk_i,
  input  logic [SPRAM_AW-1:0] addr_i,
  input  logic [3:0]          wdata_i,
  input  logic                we_i,
  input  logic                clr_i,
  output logic [3:0]          rdata_o
);

  logic [3:0] mem_q [SPRAM_DEPTH];

  // Bulk clear models the content loss of a power-down; it wins over a write.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < SPRAM_DEPTH; i++) begin
        mem_q[i] <= 4'h0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/spram256ka_model.sv
// iCE40 UltraPlus SPRAM model: 16K x 16 with nibble write masks, registered read
// data and standby/sleep/power-off controls.
module spram256ka_model
  import spram_pkg::*;
(
  input  logic                     wb_clk_i,
  input  logic                     wb_reset_ni,
  input  logic [SPRAM_AW-1:0]      ADDRESS,
  input  logic [SPRAM_DW-1:0]      DATAIN,
  input  logic [SPRAM_NIBBLES-1:0] MASKWREN,
  input  logic                     WREN,
  input  logic                     CHIPSELECT,
  input  logic                     STANDBY,
  input  logic                     SLEEP,
  input  logic                     POWEROFF,
  output logic [SPRAM_DW-1:0]      DATAOUT,
  output spram_mode_e              mode_o
);

  spram_mode_e        mode;
  logic               wr_en;
  logic               clr_en;
  logic [SPRAM_DW-1:0] rd_data;
  logic [SPRAM_DW-1:0] dout_d, dout_q;

  // Case-equality so that an unknown control never resolves to an access.
  always_comb begin
    mode = MODE_IDLE;
    if (POWEROFF === 1'b0) begin
      mode = MODE_OFF;
    end else if (SLEEP === 1'b1) begin
      mode = MODE_SLEEP;
    end else if (STANDBY === 1'b1) begin
      mode = MODE_STANDBY;
    end else if ((POWEROFF === 1'b1) && (SLEEP === 1'b0) && (STANDBY === 1'b0) &&
                 (CHIPSELECT === 1'b1) && ((WREN === 1'b0) || (WREN === 1'b1))) begin
      mode = MODE_ACCESS;
    end
  end

  // Reset suppresses anything that would change the array at that edge.
  assign wr_en  = (mode == MODE_ACCESS) && WREN && wb_reset_ni;
  assign clr_en = (mode == MODE_OFF) && wb_reset_ni;

  for (genvar g = 0; g < SPRAM_NIBBLES; g++) begin : g_lane
    spram_nibble_lane u_lane (
      .clk_i   (wb_clk_i),
      .addr_i  (ADDRESS),
      .wdata_i (DATAIN[4*g +: 4]),
      .we_i    (wr_en && MASKWREN[g]),
      .clr_i   (clr_en),
      .rdata_o (rd_data[4*g +: 4])
    );
  end

  always_comb begin
    dout_d = dout_q;
    case (mode)
      MODE_OFF, MODE_SLEEP: dout_d = '0;
      MODE_ACCESS:          if (!WREN) dout_d = rd_data;
      default:              dout_d = dout_q;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  // Low-power modes force the pins to zero without waiting for an edge.
  assign DATAOUT = ((mode == MODE_OFF) || (mode == MODE_SLEEP)) ? '0 : dout_q;
  assign mode_o  = mode;

endmodule

// File: tb/tb_spram256ka_model.sv
// Self-checking bench for spram256ka_model: directed scenarios, full sweep, random ops.
module tb_spram256ka_model;
  import spram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] addr;
  logic [15:0] din;
  logic [3:0]  mask;
  logic        wren, cs, stby, slp, poff;
  logic [15:0] dout;
  spram_mode_e mode;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [16384];
  logic [15:0] exp_q;
  logic [15:0] sb_q [$];

  spram256ka_model dut (
    .wb_clk_i    (clk),
    .wb_reset_ni (rst_n),
    .ADDRESS     (addr),
    .DATAIN      (din),
    .MASKWREN    (mask),
    .WREN        (wren),
    .CHIPSELECT  (cs),
    .STANDBY     (stby),
    .SLEEP       (slp),
    .POWEROFF    (poff),
    .DATAOUT     (dout),
    .mode_o      (mode)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_out();
    if (!rst_n || !poff || slp) return 16'h0000;
    return exp_q;
  endfunction

  // Drive one cycle's inputs at the falling edge, then apply the memory rules at the rising edge.
  task automatic step(input logic cs_v, input logic we_v, input logic [13:0] a,
                      input logic [15:0] d, input logic [3:0] m,
                      input logic sb_v, input logic sl_v, input logic po_v);
    @(negedge clk);
    cs = cs_v; wren = we_v; addr = a; din = d; mask = m;
    stby = sb_v; slp = sl_v; poff = po_v;
    @(posedge clk);
    if (!rst_n) begin
      exp_q = 16'h0000;
    end else if (!po_v) begin
      for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0000;
      exp_q = 16'h0000;
    end else if (sl_v) begin
      exp_q = 16'h0000;
    end else if (sb_v || !cs_v) begin
      exp_q = exp_q;
    end else if (we_v) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) ref_mem[a][4*i +: 4] = d[4*i +: 4];
    end else begin
      exp_q = ref_mem[a];
    end
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
    step(1'b1, 1'b1, a, d, m, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [13:0] a);
    step(1'b1, 1'b0, a, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL reset_initial: got %h want 0000", dout);
    end
    idle(); idle();
    rst_n = 1'b1;
    wr(14'h0005, 16'h1234, 4'hF);
    rd(14'h0005);
    checks++;
    if (dout !== 16'h1234) begin
      errors++; $display("FAIL reset_read_0005: got %h want 1234", dout);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL reset_async_clear: got %h want 0000", dout);
    end
    wr(14'h0005, 16'hDEAD, 4'hF);
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL reset_held: got %h want 0000", dout);
    end
    rst_n = 1'b1;
    rd(14'h0005);
    checks++;
    if (dout !== 16'h1234) begin
      errors++; $display("FAIL reset_write_suppressed: got %h want 1234", dout);
    end
  endtask

  task automatic test_mask();
    wr(14'h3FFF, 16'hFFFF, 4'hF);
    wr(14'h3FFF, 16'h0000, 4'b0101);
    rd(14'h3FFF);
    checks++;
    if (dout !== 16'hF0F0) begin
      errors++; $display("FAIL mask_0101: got %h want F0F0", dout);
    end
    wr(14'h3FFF, 16'h1234, 4'h0);
    rd(14'h3FFF);
    checks++;
    if (dout !== 16'hF0F0) begin
      errors++; $display("FAIL mask_none: got %h want F0F0", dout);
    end
  endtask

  task automatic test_hold();
    rd(14'h0005);
    checks++;
    if (dout !== 16'h1234) begin
      errors++; $display("FAIL hold_read: got %h want 1234", dout);
    end
    wr(14'h0006, 16'hABCD, 4'hF);
    checks++;
    if (dout !== 16'h1234) begin
      errors++; $display("FAIL hold_during_write: got %h want 1234", dout);
    end
    step(1'b0, 1'b1, 14'h0006, 16'h5555, 4'hF, 1'b0, 1'b0, 1'b1);
    checks++;
    if (dout !== 16'h1234) begin
      errors++; $display("FAIL hold_cs_low: got %h want 1234", dout);
    end
    step(1'b1, 1'b1, 14'h0006, 16'h7777, 4'hF, 1'b1, 1'b0, 1'b1);
    checks++;
    if (dout !== 16'h1234) begin
      errors++; $display("FAIL hold_standby: got %h want 1234", dout);
    end
    rd(14'h0006);
    checks++;
    if (dout !== 16'hABCD) begin
      errors++; $display("FAIL hold_no_write: got %h want ABCD", dout);
    end
  endtask

  task automatic test_sleep();
    rd(14'h0005);
    step(1'b1, 1'b1, 14'h0005, 16'h9999, 4'hF, 1'b0, 1'b1, 1'b1);
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL sleep_out_zero: got %h want 0000", dout);
    end
    step(1'b1, 1'b0, 14'h0005, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL sleep_read_blocked: got %h want 0000", dout);
    end
    idle();
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL sleep_wake_zero: got %h want 0000", dout);
    end
    rd(14'h0005);
    checks++;
    if (dout !== 16'h1234) begin
      errors++; $display("FAIL sleep_retained: got %h want 1234", dout);
    end
  endtask

  task automatic test_poweroff();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, 14'h0005, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (dout !== 16'h0000) begin
        errors++; $display("FAIL poweroff_out_c%0d: got %h want 0000", c, dout);
      end
    end
    idle();
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL poweroff_restore: got %h want 0000", dout);
    end
    rd(14'h0005);
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL poweroff_cleared_0005: got %h want 0000", dout);
    end
    rd(14'h3FFF);
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL poweroff_cleared_3fff: got %h want 0000", dout);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] a16;
    logic [15:0] e;
    for (int a = 0; a < 16384; a++) begin
      a16 = 16'(a);
      wr(14'(a), a16 ^ 16'hA5A5, 4'hF);
    end
    for (int a = 0; a < 16384; a++) begin
      a16 = 16'(a);
      sb_q.push_back(a16 ^ 16'hA5A5);
      rd(14'(a));
      e = sb_q.pop_front();
      checks++;
      if (dout !== e) begin
        errors++; $display("FAIL sweep_addr_%0d: got %h want %h", a, dout, e);
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sweep_queue_drain: got %0d want 0", sb_q.size());
    end
  endtask

  task automatic test_random();
    int r;
    logic [15:0] e;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           14'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)),
           (r >= 6 && r < 10), (r >= 2 && r < 6), (r >= 2));
      e = exp_out();
      checks++;
      if (dout !== e) begin
        errors++; $display("FAIL random_op_%0d: got %h want %h", n, dout, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    addr = '0; din = '0; mask = '0; wren = 1'b0; cs = 1'b0;
    stby = 1'b0; slp = 1'b0; poff = 1'b1;
    exp_q = 16'h0000;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0000;
    test_reset();
    test_mask();
    test_hold();
    test_sleep();
    test_poweroff();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
